// File: rtl/ascon_perm_ctrl.sv
// Control FSM for the ASCON-128 permutation/XOR datapath: init, AD absorption, data, finalization.
// Optional abort input is compiled in when ASCON_CTRL_ABORT_EN is defined.
module ascon_perm_ctrl #(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 6,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [CNT_W-1:0] nb_ad_blocks_i,
    input  logic [CNT_W-1:0] nb_data_blocks_i,
    input  logic             data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             data_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sel_mux_perm_o,
    output logic             sel_muxData_perm_o,
    output logic [3:0]       round_o,
    output logic             write_enable_data_o,
    output logic             write_enable_cipher_o,
    output logic             write_enable_tag_o,
    output logic             en_xor_begin_data_o,
    output logic             en_xor_begin_key_o,
    output logic             en_xor_end_lsb_o,
    output logic             en_xor_end_key_o
);

    localparam int unsigned RC_W = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_WAIT_AD   = 3'd2;
    localparam logic [2:0] S_AD        = 3'd3;
    localparam logic [2:0] S_WAIT_DATA = 3'd4;
    localparam logic [2:0] S_DATA      = 3'd5;
    localparam logic [2:0] S_FINAL     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [RC_W-1:0] RC_LAST_A = RC_W'(NB_ROUNDS_A - 1);
    localparam logic [RC_W-1:0] RC_LAST_B = RC_W'(NB_ROUNDS_B - 1);
    localparam logic [RC_W-1:0] ROUND_OFS = RC_W'(NB_ROUNDS_A - NB_ROUNDS_B);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic             decrypt_q, decrypt_d;
    logic             ready_q, busy_q, done_q;
    logic             accept;
    logic             abort_w;

`ifdef ASCON_CTRL_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    assign accept       = data_valid_i & ready_q;
    assign data_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    // Next-state and datapath control decode; accept cycles run the first block round.
    always_comb begin
        state_d               = state_q;
        rc_d                  = rc_q;
        ad_cnt_d              = ad_cnt_q;
        data_cnt_d            = data_cnt_q;
        decrypt_d             = decrypt_q;
        sel_mux_perm_o        = 1'b0;
        sel_muxData_perm_o    = 1'b0;
        round_o               = '0;
        write_enable_data_o   = 1'b0;
        write_enable_cipher_o = 1'b0;
        write_enable_tag_o    = 1'b0;
        en_xor_begin_data_o   = 1'b0;
        en_xor_begin_key_o    = 1'b0;
        en_xor_end_lsb_o      = 1'b0;
        en_xor_end_key_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_INIT;
                    rc_d       = '0;
                    decrypt_d  = decrypt_i;
                    ad_cnt_d   = nb_ad_blocks_i;
                    data_cnt_d = (nb_data_blocks_i == '0) ? CNT_ONE : nb_data_blocks_i;
                end
            end
            S_INIT: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = (rc_q != '0);
                round_o             = rc_q;
                if (rc_q == RC_LAST_A) begin
                    en_xor_end_key_o = 1'b1;
                    en_xor_end_lsb_o = (ad_cnt_q == '0);
                    state_d          = (ad_cnt_q != '0) ? S_WAIT_AD : S_WAIT_DATA;
                    rc_d             = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_WAIT_AD: begin
                if (accept) begin
                    write_enable_data_o = 1'b1;
                    sel_mux_perm_o      = 1'b1;
                    en_xor_begin_data_o = 1'b1;
                    round_o             = ROUND_OFS;
                    rc_d                = RC_W'(1);
                    state_d             = S_AD;
                end
            end
            S_AD: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                round_o             = ROUND_OFS + rc_q;
                if (rc_q == RC_LAST_B) begin
                    en_xor_end_lsb_o = (ad_cnt_q == CNT_ONE);
                    ad_cnt_d         = ad_cnt_q - CNT_ONE;
                    state_d          = (ad_cnt_q > CNT_ONE) ? S_WAIT_AD : S_WAIT_DATA;
                    rc_d             = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_WAIT_DATA: begin
                if (accept) begin
                    write_enable_data_o   = 1'b1;
                    write_enable_cipher_o = 1'b1;
                    sel_mux_perm_o        = 1'b1;
                    sel_muxData_perm_o    = decrypt_q;
                    en_xor_begin_data_o   = 1'b1;
                    data_cnt_d            = data_cnt_q - CNT_ONE;
                    rc_d                  = RC_W'(1);
                    // Last block's first round is round 0 of the finalization permutation.
                    if (data_cnt_q == CNT_ONE) begin
                        en_xor_begin_key_o = 1'b1;
                        round_o            = '0;
                        state_d            = S_FINAL;
                    end else begin
                        round_o = ROUND_OFS;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                round_o             = ROUND_OFS + rc_q;
                if (rc_q == RC_LAST_B) begin
                    state_d = S_WAIT_DATA;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_FINAL: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                round_o             = rc_q;
                if (rc_q == RC_LAST_A) begin
                    en_xor_end_key_o   = 1'b1;
                    write_enable_tag_o = 1'b1;
                    state_d            = S_DONE;
                    rc_d               = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rc_d    = '0;
            end
        endcase

        // Abort wins over everything, including a start in IDLE.
        if (abort_w) begin
            state_d               = S_IDLE;
            rc_d                  = '0;
            ad_cnt_d              = ad_cnt_q;
            data_cnt_d            = data_cnt_q;
            decrypt_d             = decrypt_q;
            sel_mux_perm_o        = 1'b0;
            sel_muxData_perm_o    = 1'b0;
            round_o               = '0;
            write_enable_data_o   = 1'b0;
            write_enable_cipher_o = 1'b0;
            write_enable_tag_o    = 1'b0;
            en_xor_begin_data_o   = 1'b0;
            en_xor_begin_key_o    = 1'b0;
            en_xor_end_lsb_o      = 1'b0;
            en_xor_end_key_o      = 1'b0;
        end
    end

    // State, counters and the state-derived status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rc_q       <= '0;
            ad_cnt_q   <= '0;
            data_cnt_q <= '0;
            decrypt_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            ad_cnt_q   <= ad_cnt_d;
            data_cnt_q <= data_cnt_d;
            decrypt_q  <= decrypt_d;
            ready_q    <= (state_d == S_WAIT_AD) || (state_d == S_WAIT_DATA);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: per-cycle output vectors against a block-schedule model.
// Define ASCON_CTRL_ABORT_EN to also exercise the abort input.
module tb_ascon_perm_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       decrypt_i;
    logic [7:0] nb_ad_blocks_i;
    logic [7:0] nb_data_blocks_i;
    logic       data_valid_i;
    logic       abort_r;
    logic       data_ready_o, busy_o, done_o, sel_mux_perm_o, sel_muxData_perm_o;
    logic [3:0] round_o;
    logic       write_enable_data_o, write_enable_cipher_o, write_enable_tag_o;
    logic       en_xor_begin_data_o, en_xor_begin_key_o, en_xor_end_lsb_o, en_xor_end_key_o;

    always #5 clk_i = ~clk_i;

    ascon_perm_ctrl #(.NB_ROUNDS_A(12), .NB_ROUNDS_B(6), .CNT_W(8)) u_dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .decrypt_i             (decrypt_i),
        .nb_ad_blocks_i        (nb_ad_blocks_i),
        .nb_data_blocks_i      (nb_data_blocks_i),
        .data_valid_i          (data_valid_i),
`ifdef ASCON_CTRL_ABORT_EN
        .abort_i               (abort_r),
`endif
        .data_ready_o          (data_ready_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .sel_mux_perm_o        (sel_mux_perm_o),
        .sel_muxData_perm_o    (sel_muxData_perm_o),
        .round_o               (round_o),
        .write_enable_data_o   (write_enable_data_o),
        .write_enable_cipher_o (write_enable_cipher_o),
        .write_enable_tag_o    (write_enable_tag_o),
        .en_xor_begin_data_o   (en_xor_begin_data_o),
        .en_xor_begin_key_o    (en_xor_begin_key_o),
        .en_xor_end_lsb_o      (en_xor_end_lsb_o),
        .en_xor_end_key_o      (en_xor_end_key_o)
    );

    // Model item: either a point where the controller waits for a block, or one expected cycle.
    typedef struct {
        bit          is_wait;
        logic [15:0] v;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    wire [15:0] obs = {data_ready_o, busy_o, done_o, sel_mux_perm_o, sel_muxData_perm_o, round_o,
                       write_enable_data_o, write_enable_cipher_o, write_enable_tag_o,
                       en_xor_begin_data_o, en_xor_begin_key_o, en_xor_end_lsb_o, en_xor_end_key_o};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] mk(input logic rdy, input logic bsy, input logic dn,
                                       input logic selp, input logic seld, input int rnd,
                                       input logic wed, input logic wec, input logic wet,
                                       input logic xbd, input logic xbk, input logic xel,
                                       input logic xek);
        return {rdy, bsy, dn, selp, seld, 4'(rnd), wed, wec, wet, xbd, xbk, xel, xek};
    endfunction

    function automatic void push(input bit w, input logic [15:0] v);
        item_t it;
        it.is_wait = w;
        it.v       = v;
        q.push_back(it);
    endfunction

    // Expected cycle schedule of one whole operation, written block by block.
    function automatic void build_op(input int nb_ad, input int nb_data, input bit dec);
        int nd;
        nd = (nb_data == 0) ? 1 : nb_data;
        q.delete();
        for (int r = 0; r < 12; r++)
            push(0, mk(0, 1, 0, r != 0, 0, r, 1, 0, 0, 0, 0, (r == 11) && (nb_ad == 0), r == 11));
        for (int b = 0; b < nb_ad; b++) begin
            push(1, '0);
            push(0, mk(1, 1, 0, 1, 0, 6, 1, 0, 0, 1, 0, 0, 0));
            for (int r = 7; r < 12; r++)
                push(0, mk(0, 1, 0, 1, 0, r, 1, 0, 0, 0, 0, (r == 11) && (b == nb_ad - 1), 0));
        end
        for (int d = 0; d < nd; d++) begin
            bit last;
            last = (d == nd - 1);
            push(1, '0);
            push(0, mk(1, 1, 0, 1, dec, last ? 0 : 6, 1, 1, 0, 1, last, 0, 0));
            if (!last) begin
                for (int r = 7; r < 12; r++)
                    push(0, mk(0, 1, 0, 1, 0, r, 1, 0, 0, 0, 0, 0, 0));
            end else begin
                for (int r = 1; r < 12; r++)
                    push(0, mk(0, 1, 0, 1, 0, r, 1, 0, r == 11, 0, 0, 0, r == 11));
            end
        end
        push(0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // Runs one operation; pct is valid probability, stall window forces valid low, rst/abort/glitch at cycle.
    task automatic run_op(input string tag, input int nb_ad, input int nb_data, input bit dec,
                          input int pct, input int st_lo, input int st_hi,
                          input int rst_cyc, input int abort_cyc, input int glitch_cyc);
        int          cyc, stalls, done_cyc, nd;
        logic [15:0] exp;
        item_t       it;
        bit          cut;
        nd = (nb_data == 0) ? 1 : nb_data;
        build_op(nb_ad, nb_data, dec);
        @(posedge clk_i); #1;
        rst_i            = 1'b0;
        abort_r          = 1'b0;
        start_i          = 1'b1;
        decrypt_i        = dec;
        nb_ad_blocks_i   = 8'(nb_ad);
        nb_data_blocks_i = 8'(nb_data);
        data_valid_i     = 1'($urandom_range(1));
        @(negedge clk_i);
        check_eq({tag, "_start"}, 32'(obs), 32'h0);
        cyc = 0; stalls = 0; done_cyc = -1; cut = 0;
        while (q.size() > 0 && cyc < 2000 && !cut) begin
            @(posedge clk_i); #1;
            cyc++;
            start_i          = (cyc == glitch_cyc);
            decrypt_i        = 1'($urandom_range(1));
            nb_ad_blocks_i   = 8'($urandom);
            nb_data_blocks_i = 8'($urandom);
            data_valid_i     = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 : (int'($urandom_range(99)) < pct);
            rst_i            = (cyc == rst_cyc);
            abort_r          = (cyc == abort_cyc);
            if (q[0].is_wait) begin
                if (data_valid_i) begin
                    void'(q.pop_front());
                    it  = q.pop_front();
                    exp = it.v;
                end else begin
                    exp = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    stalls++;
                end
            end else begin
                it  = q.pop_front();
                exp = it.v;
            end
            if (abort_r) exp = exp & 16'hE000;
            @(negedge clk_i);
            check_eq(tag, 32'(obs), 32'(exp));
            if (exp[13]) done_cyc = cyc;
            if (rst_i || abort_r) cut = 1;
        end
        if (!cut) begin
            check_eq({tag, "_timeout"}, 32'(q.size()), 32'h0);
            check_eq({tag, "_latency"}, 32'(done_cyc), 32'(12 + 6 * nb_ad + 6 * (nd - 1) + 12 + 1 + stalls));
        end
        q.delete();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; decrypt_i = 1'b0; abort_r = 1'b0;
        nb_ad_blocks_i = '0; nb_data_blocks_i = '0; data_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("reset", 32'(obs), 32'h0);

        run_op("enc_0ad_1d",       0, 1, 0, 100, -1, -1, -1, -1, -1);
        run_op("enc_2ad_2d_stall", 2, 2, 0, 100, 19, 21, -1, -1, -1);
        run_op("dec_1ad_3d",       1, 3, 1, 100, -1, -1, -1, -1, -1);
        run_op("rst_final5",       0, 1, 0, 100, -1, -1, 18, -1, -1);
        run_op("glitch_data",      0, 2, 0, 100, -1, -1, -1, -1, 14);
        run_op("nb_data_zero",     0, 0, 0, 100, -1, -1, -1, -1, -1);
`ifdef ASCON_CTRL_ABORT_EN
        run_op("abort_ad8",        1, 1, 0, 100, -1, -1, -1, 15, -1);
        run_op("after_abort",      1, 1, 1, 100, -1, -1, -1, -1, -1);
        @(posedge clk_i); #1;
        start_i = 1'b1; abort_r = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; abort_r = 1'b0;
        @(negedge clk_i);
        check_eq("abort_over_start", 32'(obs), 32'h0);
`endif
        for (int i = 0; i < 10; i++)
            run_op("rand", int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)),
                   60, -1, -1, -1, -1, -1);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0; rst_i = 1'b0; abort_r = 1'b0;
            @(negedge clk_i);
            check_eq("idle_tail", 32'(obs), 32'h0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
